mandel_view_ctrl: RTL and testbench

View controller that sits directly upstream of the Mandelbrot renderer. It converts single-cycle pan and zoom requests into the renderer's `x_start`, `y_start` and `step` operands, and issues a one-cycle `start` pulse. View changes requested during a render are queued until that render's `done`, so a frame is never restarted mid-draw. An initial frame is rendered automatically after reset.

---
 rtl/mandel_pkg.sv | 36 +++
 rtl/mandel_view_ctrl_if.sv | 23 ++
 rtl/fp_sat_addsub.sv | 35 +++
 rtl/mandel_view_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mandel_view_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot view controller: fixed-point widths,
// reset/limit defaults, FSM state and request-bit index enums.
package mandel_pkg;

  localparam int FB_WIDTH_D   = 320;
  localparam int FB_HEIGHT_D  = 180;
  localparam int FP_WIDTH_D   = 25;
  localparam int FP_INT_D     = 4;
  localparam int INIT_CX_D    = -1572864;
  localparam int INIT_CY_D    = 0;
  localparam int INIT_STEP_D  = 19661;
  localparam int STEP_MAX_D   = 19661;
  localparam int PAN_PX_D     = 16;
  localparam int CENTRE_LIM_D = 4194304;

  localparam int REQ_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_CALC  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } view_state_e;

  // Bit positions inside the pending-request register.
  typedef enum logic [2:0] {
    REQ_UP   = 3'd0,
    REQ_DN   = 3'd1,
    REQ_LT   = 3'd2,
    REQ_RT   = 3'd3,
    REQ_ZIN  = 3'd4,
    REQ_ZOUT = 3'd5
  } req_idx_e;

endpackage

// File: rtl/mandel_view_ctrl_if.sv
// Render-side port bundle: operands and start pulse out, busy/done back.
interface mandel_view_ctrl_if
  import mandel_pkg::*;
#(
  parameter int FP_WIDTH = FP_WIDTH_D
);
  logic                       start;
  logic signed [FP_WIDTH-1:0] x_start;
  logic signed [FP_WIDTH-1:0] y_start;
  logic signed [FP_WIDTH-1:0] step;
  logic                       render_busy;
  logic                       render_done;

  modport master (
    output start, x_start, y_start, step,
    input  render_busy, render_done
  );

  modport slave (
    input  start, x_start, y_start, step,
    output render_busy, render_done
  );
endinterface

// File: rtl/fp_sat_addsub.sv
// Signed fixed-point add/subtract whose result is clamped to +/-LIM.
module fp_sat_addsub
  import mandel_pkg::*;
#(
  parameter int W   = FP_WIDTH_D,
  parameter int LIM = CENTRE_LIM_D
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic                i_sub,
  output logic signed [W-1:0] o_y
);

  localparam logic signed [W:0] LIM_P = (W+1)'(LIM);
  localparam logic signed [W:0] LIM_N = -LIM_P;

  logic signed [W:0] w_sum;

  // One guard bit keeps the raw sum exact before clamping.
  always_comb begin
    if (i_sub) begin
      w_sum = (W+1)'(i_a) - (W+1)'(i_b);
    end else begin
      w_sum = (W+1)'(i_a) + (W+1)'(i_b);
    end
    if (w_sum > LIM_P) begin
      o_y = LIM_P[W-1:0];
    end else if (w_sum < LIM_N) begin
      o_y = LIM_N[W-1:0];
    end else begin
      o_y = w_sum[W-1:0];
    end
  end

endmodule

// File: rtl/mandel_view_ctrl.sv
// Pan/zoom view controller feeding the Mandelbrot renderer. Optional feature:
// VIEW_CTRL_AUTOZOOM_EN (continuous zoom-in after each idle render_done).
module mandel_view_ctrl
  import mandel_pkg::*;
#(
  parameter int FB_WIDTH   = FB_WIDTH_D,
  parameter int FB_HEIGHT  = FB_HEIGHT_D,
  parameter int FP_WIDTH   = FP_WIDTH_D,
  parameter int FP_INT     = FP_INT_D,
  parameter int INIT_CX    = INIT_CX_D,
  parameter int INIT_CY    = INIT_CY_D,
  parameter int INIT_STEP  = INIT_STEP_D,
  parameter int STEP_MAX   = STEP_MAX_D,
  parameter int PAN_PX     = PAN_PX_D,
  parameter int CENTRE_LIM = CENTRE_LIM_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_dn,
  input  logic               btn_lt,
  input  logic               btn_rt,
  input  logic               btn_zin,
  input  logic               btn_zout,
  mandel_view_ctrl_if.master rif,
  output logic               pending
);

  localparam int W  = FP_WIDTH;
  localparam int W2 = 2 * FP_WIDTH;

  localparam logic signed [W2-1:0] HALF_W_C = W2'(FB_WIDTH / 2);
  localparam logic signed [W2-1:0] HALF_H_C = W2'(FB_HEIGHT / 2);
  localparam logic signed [W2-1:0] PAN_C    = W2'(PAN_PX);
  localparam logic signed [W-1:0]  CX0_C    = W'(INIT_CX);
  localparam logic signed [W-1:0]  CY0_C    = W'(INIT_CY);
  localparam logic signed [W-1:0]  STEP0_C  = W'(INIT_STEP);
  localparam logic signed [W-1:0]  STEP_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic signed [W:0]    STEP_MAX_C = (W+1)'(STEP_MAX);

  view_state_e         r_state;
  logic [REQ_W-1:0]    r_pend;
  logic signed [W-1:0] r_cx;
  logic signed [W-1:0] r_cy;
  logic signed [W-1:0] r_step;
  logic signed [W-1:0] r_x;
  logic signed [W-1:0] r_y;
  logic signed [W-1:0] r_step_o;
  logic                r_start;

  logic [REQ_W-1:0]     w_btn;
  logic signed [W2-1:0] w_step_wide;
  logic signed [W2-1:0] w_pan_wide;
  logic signed [W2-1:0] w_xo_wide;
  logic signed [W2-1:0] w_yo_wide;
  logic signed [W-1:0]  w_pan;
  logic signed [W-1:0]  w_x_calc;
  logic signed [W-1:0]  w_y_calc;
  logic signed [W-1:0]  w_cx_sat;
  logic signed [W-1:0]  w_cy_sat;
  logic signed [W-1:0]  w_cx_nxt;
  logic signed [W-1:0]  w_cy_nxt;
  logic signed [W-1:0]  w_step_half;
  logic signed [W:0]    w_step_dbl;
  logic signed [W-1:0]  w_step_nxt;
  logic                 w_zin;
  logic                 w_zout;
  logic [4:0]           w_unused_cfg;

  assign w_btn = {btn_zout, btn_zin, btn_rt, btn_lt, btn_dn, btn_up};

  // Double-width products, truncated back to the operand width.
  always_comb begin
    w_step_wide = W2'(r_step);
    w_pan_wide  = w_step_wide * PAN_C;
    w_xo_wide   = w_step_wide * HALF_W_C;
    w_yo_wide   = w_step_wide * HALF_H_C;
    w_pan       = w_pan_wide[W-1:0];
    w_x_calc    = r_cx - w_xo_wide[W-1:0];
    w_y_calc    = r_cy - w_yo_wide[W-1:0];
  end

  fp_sat_addsub #(.W(W), .LIM(CENTRE_LIM)) u_cx_sat (
    .i_a  (r_cx),
    .i_b  (w_pan),
    .i_sub(r_pend[REQ_LT]),
    .o_y  (w_cx_sat)
  );

  fp_sat_addsub #(.W(W), .LIM(CENTRE_LIM)) u_cy_sat (
    .i_a  (r_cy),
    .i_b  (w_pan),
    .i_sub(r_pend[REQ_UP]),
    .o_y  (w_cy_sat)
  );

  // Opposite pans and opposite zooms cancel; pan uses the pre-zoom step.
  always_comb begin
    w_zin       = r_pend[REQ_ZIN] & ~r_pend[REQ_ZOUT];
    w_zout      = r_pend[REQ_ZOUT] & ~r_pend[REQ_ZIN];
    w_step_half = r_step >>> 1;
    w_step_dbl  = (W+1)'(r_step) <<< 1;
    if (r_pend[REQ_LT] ^ r_pend[REQ_RT]) begin
      w_cx_nxt = w_cx_sat;
    end else begin
      w_cx_nxt = r_cx;
    end
    if (r_pend[REQ_UP] ^ r_pend[REQ_DN]) begin
      w_cy_nxt = w_cy_sat;
    end else begin
      w_cy_nxt = r_cy;
    end
    if (w_zin) begin
      if (w_step_half < STEP_ONE) begin
        w_step_nxt = STEP_ONE;
      end else begin
        w_step_nxt = w_step_half;
      end
    end else if (w_zout) begin
      if (w_step_dbl > STEP_MAX_C) begin
        w_step_nxt = STEP_MAX_C[W-1:0];
      end else begin
        w_step_nxt = w_step_dbl[W-1:0];
      end
    end else begin
      w_step_nxt = r_step;
    end
  end

  // View FSM: requests accumulate in any state, are consumed in APPLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_CALC;
      r_pend   <= {REQ_W{1'b0}};
      r_cx     <= CX0_C;
      r_cy     <= CY0_C;
      r_step   <= STEP0_C;
      r_x      <= {W{1'b0}};
      r_y      <= {W{1'b0}};
      r_step_o <= STEP0_C;
      r_start  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_pend  <= r_pend | w_btn;
      case (r_state)
        ST_IDLE: begin
          // Looking at the raw buttons too gives APPLY on the very next cycle.
          if ((r_pend != {REQ_W{1'b0}}) || (w_btn != {REQ_W{1'b0}})) begin
            r_state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          r_pend  <= w_btn;
          r_cx    <= w_cx_nxt;
          r_cy    <= w_cy_nxt;
          r_step  <= w_step_nxt;
          r_state <= ST_CALC;
        end
        ST_CALC: begin
          r_x      <= w_x_calc;
          r_y      <= w_y_calc;
          r_step_o <= r_step;
          r_start  <= 1'b1;
          r_state  <= ST_START;
        end
        ST_START: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rif.render_done) begin
            r_state <= ST_IDLE;
`ifdef VIEW_CTRL_AUTOZOOM_EN
            if ((r_pend == {REQ_W{1'b0}}) && (w_btn == {REQ_W{1'b0}}) &&
                (r_step != STEP_ONE)) begin
              r_pend[REQ_ZIN] <= 1'b1;
            end
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rif.start   = r_start;
  assign rif.x_start = r_x;
  assign rif.y_start = r_y;
  assign rif.step    = r_step_o;
  assign pending     = |r_pend;

  // Busy is informational; product high halves are discarded by design.
  assign w_unused_cfg = {^w_pan_wide[W2-1:W], ^w_xo_wide[W2-1:W],
                         ^w_yo_wide[W2-1:W], rif.render_busy, 1'(FP_INT)};

endmodule

// File: tb/tb_mandel_view_ctrl.sv
// Randomised self-checking bench for mandel_view_ctrl against a view model.
module tb_mandel_view_ctrl;

  localparam longint INIT_CX   = -1572864;
  localparam longint INIT_CY   = 0;
  localparam longint INIT_STEP = 19661;
  localparam longint STEP_MAX  = 19661;
  localparam longint PAN_PX    = 16;
  localparam longint LIM       = 4194304;
  localparam longint HALF_W    = 160;
  localparam longint HALF_H    = 90;
  localparam int     NO_START  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up, btn_dn, btn_lt, btn_rt, btn_zin, btn_zout;
  logic pending;

  int n_checks = 0;
  int n_fail   = 0;

  longint     m_cx, m_cy, m_step;
  logic [5:0] m_pend;

  mandel_view_ctrl_if #(.FP_WIDTH(25)) rif ();

  mandel_view_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .btn_lt  (btn_lt),
    .btn_rt  (btn_rt),
    .btn_zin (btn_zin),
    .btn_zout(btn_zout),
    .rif     (rif),
    .pending (pending)
  );

  always #5 clk = ~clk;

  function automatic longint clampc(longint v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic void model_reset();
    m_cx = INIT_CX; m_cy = INIT_CY; m_step = INIT_STEP; m_pend = 6'b0;
  endfunction

  // Bits: 0 up, 1 dn, 2 lt, 3 rt, 4 zin, 5 zout.
  function automatic void model_apply();
    longint pan = m_step * PAN_PX;
    if (m_pend[3] && !m_pend[2]) m_cx = clampc(m_cx + pan);
    if (m_pend[2] && !m_pend[3]) m_cx = clampc(m_cx - pan);
    if (m_pend[1] && !m_pend[0]) m_cy = clampc(m_cy + pan);
    if (m_pend[0] && !m_pend[1]) m_cy = clampc(m_cy - pan);
    if (m_pend[4] && !m_pend[5]) begin
      m_step = m_step / 2;
      if (m_step < 1) m_step = 1;
    end
    if (m_pend[5] && !m_pend[4]) begin
      m_step = m_step * 2;
      if (m_step > STEP_MAX) m_step = STEP_MAX;
    end
    m_pend = 6'b0;
  endfunction

  function automatic longint exp_x();
    return m_cx - m_step * HALF_W;
  endfunction

  function automatic longint exp_y();
    return m_cy - m_step * HALF_H;
  endfunction

  task automatic drive_btns(input logic [5:0] b);
    {btn_zout, btn_zin, btn_rt, btn_lt, btn_dn, btn_up} = b;
  endtask

  task automatic wait_start(output int lat);
    lat = 1;
    while (rif.start !== 1'b1 && lat < NO_START) begin
      @(negedge clk);
      lat++;
    end
    if (rif.start === 1'b1) rif.render_busy = 1'b1;
  endtask

  task automatic press(input logic [5:0] b, output int lat);
    drive_btns(b);
    m_pend |= b;
    model_apply();
    @(negedge clk);
    drive_btns(6'b0);
    wait_start(lat);
  endtask

  task automatic end_render(input logic [5:0] b, output int lat, output bit exp_start);
    rif.render_done = 1'b1;
    rif.render_busy = 1'b0;
    drive_btns(b);
    m_pend |= b;
`ifdef VIEW_CTRL_AUTOZOOM_EN
    if (m_pend == 6'b0 && m_step != 1) m_pend = 6'b010000;
`endif
    exp_start = (m_pend != 6'b0);
    if (exp_start) model_apply();
    @(negedge clk);
    rif.render_done = 1'b0;
    drive_btns(6'b0);
    wait_start(lat);
  endtask

  task automatic render_delay();
    int n = $urandom_range(1, 4);
    repeat (n) @(negedge clk);
  endtask

  task automatic finish_idle();
    int lat;
    bit es;
    render_delay();
    end_render(6'b0, lat, es);
  endtask

  task automatic do_reset();
    int lat;
    rst = 1'b1;
    rif.render_done = 1'b0;
    drive_btns(6'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    wait_start(lat);
  endtask

  task automatic test_reset();
    int lat;
    int starts;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rif.start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b want 0", rif.start); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %0b want 0", pending); end
    n_checks++; if (longint'(rif.step) !== INIT_STEP) begin n_fail++; $display("FAIL reset_step: got %0d want %0d", rif.step, INIT_STEP); end
    n_checks++; if (rif.x_start !== 25'sd0 || rif.y_start !== 25'sd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d want 0,0", rif.x_start, rif.y_start); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    wait_start(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL first_start_latency: got %0d want 1", lat); end
    n_checks++; if (longint'(rif.x_start) !== -64'sd4718624) begin n_fail++; $display("FAIL first_x: got %0d want -4718624", rif.x_start); end
    n_checks++; if (longint'(rif.y_start) !== -64'sd1769490) begin n_fail++; $display("FAIL first_y: got %0d want -1769490", rif.y_start); end
    n_checks++; if (longint'(rif.step) !== 64'sd19661) begin n_fail++; $display("FAIL first_step: got %0d want 19661", rif.step); end
    starts = 0;
    repeat (8) begin
      @(negedge clk);
      if (rif.start === 1'b1) starts++;
    end
    n_checks++; if (starts !== 0) begin n_fail++; $display("FAIL first_single_pulse: got %0d extra starts want 0", starts); end
  endtask

`ifdef VIEW_CTRL_AUTOZOOM_EN
  task automatic test_step_floor();
    int lat;
    bit es;
    int renders = 0;
    for (int i = 0; i < 25; i++) begin
      render_delay();
      end_render(6'b0, lat, es);
      if (!es) break;
      renders++;
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL autozoom_latency: got %0d want 4", lat); end
      n_checks++; if (longint'(rif.step) !== m_step) begin n_fail++; $display("FAIL autozoom_step: got %0d want %0d", rif.step, m_step); end
    end
    n_checks++; if (renders !== 14) begin n_fail++; $display("FAIL autozoom_count: got %0d want 14", renders); end
    n_checks++; if (lat !== NO_START) begin n_fail++; $display("FAIL autozoom_stop: start seen after %0d cycles, want none", lat); end
    n_checks++; if (rif.step !== 25'sd1) begin n_fail++; $display("FAIL autozoom_floor: got %0d want 1", rif.step); end
  endtask
`else
  task automatic test_zoom_in();
    int lat;
    bit es;
    render_delay();
    end_render(6'b0, lat, es);
    n_checks++; if (lat !== NO_START) begin n_fail++; $display("FAIL idle_no_start: start after %0d cycles, want none", lat); end
    press(6'b010000, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL zin_latency: got %0d want 3", lat); end
    n_checks++; if (longint'(rif.step) !== 64'sd9830) begin n_fail++; $display("FAIL zin_step: got %0d want 9830", rif.step); end
    n_checks++; if (longint'(rif.x_start) !== -64'sd3145664) begin n_fail++; $display("FAIL zin_x: got %0d want -3145664", rif.x_start); end
    n_checks++; if (longint'(rif.y_start) !== -64'sd884700) begin n_fail++; $display("FAIL zin_y: got %0d want -884700", rif.y_start); end
  endtask

  task automatic test_zoom_out_limit();
    int lat;
    finish_idle();
    press(6'b100000, lat);
    n_checks++; if (longint'(rif.step) !== 64'sd19660) begin n_fail++; $display("FAIL zout_double: got %0d want 19660", rif.step); end
    finish_idle();
    press(6'b100000, lat);
    n_checks++; if (longint'(rif.step) !== STEP_MAX) begin n_fail++; $display("FAIL zout_clamp: got %0d want %0d", rif.step, STEP_MAX); end
    finish_idle();
    press(6'b100000, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL zout_reissue_latency: got %0d want 3", lat); end
    n_checks++; if (longint'(rif.step) !== STEP_MAX) begin n_fail++; $display("FAIL zout_at_max: got %0d want %0d", rif.step, STEP_MAX); end
    n_checks++; if (longint'(rif.x_start) !== exp_x()) begin n_fail++; $display("FAIL zout_x: got %0d want %0d", rif.x_start, exp_x()); end
  endtask

  task automatic test_queued_pan();
    int lat;
    int starts = 0;
    bit es;
    do_reset();
    render_delay();
    drive_btns(6'b001000);
    m_pend |= 6'b001000;
    @(negedge clk);
    drive_btns(6'b0);
    repeat (6) begin
      if (rif.start === 1'b1) starts++;
      @(negedge clk);
    end
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL queued_pending: got %0b want 1", pending); end
    n_checks++; if (starts !== 0) begin n_fail++; $display("FAIL queued_no_start: got %0d starts want 0", starts); end
    end_render(6'b0, lat, es);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL queued_latency: got %0d want 4", lat); end
    n_checks++; if (longint'(rif.x_start) !== -64'sd1258288 - 64'sd3145760) begin n_fail++; $display("FAIL queued_x: got %0d want -4404048", rif.x_start); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL queued_cleared: got %0b want 0", pending); end
  endtask

  task automatic test_cancel();
    int lat;
    do_reset();
    finish_idle();
    press(6'b001101, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL cancel_latency: got %0d want 3", lat); end
    n_checks++; if (longint'(rif.x_start) !== -64'sd4718624) begin n_fail++; $display("FAIL cancel_x: got %0d want -4718624", rif.x_start); end
    n_checks++; if (longint'(rif.y_start) !== -64'sd314576 - 64'sd1769490) begin n_fail++; $display("FAIL cancel_y: got %0d want -2084066", rif.y_start); end
  endtask

  task automatic test_saturation();
    int lat;
    longint cx_obs;
    longint cx_prev = -LIM;
    for (int i = 0; i < 20; i++) begin
      finish_idle();
      press(6'b001000, lat);
      cx_obs = longint'(rif.x_start) + longint'(rif.step) * HALF_W;
      n_checks++; if (longint'(rif.x_start) !== exp_x()) begin n_fail++; $display("FAIL sat_x[%0d]: got %0d want %0d", i, rif.x_start, exp_x()); end
      n_checks++; if (cx_obs < cx_prev || cx_obs > LIM) begin n_fail++; $display("FAIL sat_monotonic[%0d]: got cx %0d after %0d", i, cx_obs, cx_prev); end
      cx_prev = cx_obs;
    end
    n_checks++; if (cx_prev !== LIM) begin n_fail++; $display("FAIL sat_final_cx: got %0d want %0d", cx_prev, LIM); end
  endtask

  task automatic test_random();
    int lat;
    bit es;
    logic [5:0] b;
    for (int i = 0; i < 30; i++) begin
      render_delay();
      if ($urandom_range(0, 1) == 1) begin
        b = 6'($urandom_range(1, 63));
        drive_btns(b);
        m_pend |= b;
        @(negedge clk);
        drive_btns(6'b0);
        n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL rand_pending[%0d]: got %0b want 1", i, pending); end
      end
      render_delay();
      b = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'b0;
      end_render(b, lat, es);
      if (es) begin
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rand_queued_latency[%0d]: got %0d want 4", i, lat); end
      end else begin
        n_checks++; if (lat !== NO_START) begin n_fail++; $display("FAIL rand_no_start[%0d]: start after %0d cycles", i, lat); end
        b = 6'($urandom_range(1, 63));
        press(b, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rand_press_latency[%0d]: got %0d want 3", i, lat); end
      end
      n_checks++; if (longint'(rif.step) !== m_step) begin n_fail++; $display("FAIL rand_step[%0d]: got %0d want %0d", i, rif.step, m_step); end
      n_checks++; if (longint'(rif.x_start) !== exp_x()) begin n_fail++; $display("FAIL rand_x[%0d]: got %0d want %0d", i, rif.x_start, exp_x()); end
      n_checks++; if (longint'(rif.y_start) !== exp_y()) begin n_fail++; $display("FAIL rand_y[%0d]: got %0d want %0d", i, rif.y_start, exp_y()); end
    end
  endtask
`endif

  initial begin
    rif.render_done = 1'b0;
    rif.render_busy = 1'b0;
    drive_btns(6'b0);
    model_reset();
    test_reset();
`ifdef VIEW_CTRL_AUTOZOOM_EN
    test_step_floor();
`else
    test_zoom_in();
    test_zoom_out_limit();
    test_queued_pan();
    test_cancel();
    test_saturation();
    test_random();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
